// File: rtl/freq_meas_pkg.sv
// Shared types and constants for the frequency-meter control block.
package freq_meas_pkg;

  localparam int unsigned DEF_N_W          = 22;
  localparam int unsigned DEF_M_W          = 13;
  localparam int unsigned DEF_TO_W         = 24;
  localparam int unsigned DEF_AVG_LOG2_MAX = 3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_WAIT = 3'd2,
    S_ACC  = 3'd3,
    S_RPT  = 3'd4
  } state_e;

  localparam logic [2:0] ADDR_CTRL     = 3'd0;
  localparam logic [2:0] ADDR_STATUS   = 3'd1;
  localparam logic [2:0] ADDR_N_RES    = 3'd2;
  localparam logic [2:0] ADDR_M_RES    = 3'd3;
  localparam logic [2:0] ADDR_TIMEOUT  = 3'd4;
  localparam logic [2:0] ADDR_MEAS_CNT = 3'd5;
  localparam logic [2:0] ADDR_DIV      = 3'd6;

  localparam int CTRL_RUN     = 0;
  localparam int CTRL_ONESHOT = 1;
  localparam int CTRL_AVG_LO  = 4;
  localparam int CTRL_IRQ_EN  = 8;
  localparam int CTRL_TRACK   = 9;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_VALID   = 1;
  localparam int STAT_TIMEOUT = 2;
  localparam int STAT_OVERRUN = 3;

endpackage

// File: rtl/freq_meas_ctrl_if.sv
// Avalon-MM slave bus bundle for the frequency-meter control block.
interface freq_meas_ctrl_if;
  import freq_meas_pkg::*;

  logic [2:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;

  modport master (output address, write, writedata, read, input readdata);
  modport slave  (input address, write, writedata, read, output readdata);

endinterface

// File: rtl/freq_meas_accum.sv
// Accumulates meter results over 2^avg_log2 samples and presents the
// truncated average; the depth is latched at the start of each average.
module freq_meas_accum
  import freq_meas_pkg::*;
#(
  parameter int N_W          = DEF_N_W,
  parameter int M_W          = DEF_M_W,
  parameter int AVG_LOG2_MAX = DEF_AVG_LOG2_MAX
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_clr,
  input  logic           i_add,
  input  logic           i_sample,
  input  logic [1:0]     i_avg_log2,
  input  logic [N_W-1:0] i_n,
  input  logic [M_W-1:0] i_m,
  output logic           o_last,
  output logic [N_W-1:0] o_avg_n,
  output logic [M_W-1:0] o_avg_m
);

  localparam int K_W = AVG_LOG2_MAX + 1;

  logic [N_W+AVG_LOG2_MAX-1:0] r_acc_n;
  logic [M_W+AVG_LOG2_MAX-1:0] r_acc_m;
  logic [K_W-1:0]              r_k;
  logic [1:0]                  r_avg;
  logic [K_W-1:0]              w_k_nxt;
  logic [K_W-1:0]              w_k_tgt;

  assign w_k_nxt = r_k + 1'b1;
  assign w_k_tgt = K_W'(1) << r_avg;
  // The sample being added now is the last one of this average
  assign o_last  = (w_k_nxt == w_k_tgt);
  assign o_avg_n = r_acc_n[r_avg +: N_W];
  assign o_avg_m = r_acc_m[r_avg +: M_W];

  // Sums, sample count and latched averaging depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_n <= '0;
      r_acc_m <= '0;
      r_k     <= '0;
      r_avg   <= '0;
    end else begin
      if (i_clr) begin
        r_acc_n <= '0;
        r_acc_m <= '0;
        r_k     <= '0;
      end else if (i_add) begin
        r_acc_n <= r_acc_n + {{AVG_LOG2_MAX{1'b0}}, i_n};
        r_acc_m <= r_acc_m + {{AVG_LOG2_MAX{1'b0}}, i_m};
        r_k     <= w_k_nxt;
      end
      if (i_sample && (r_k == '0)) begin
        r_avg <= i_avg_log2;
      end
    end
  end

endmodule

// File: rtl/freq_meas_ctrl.sv
// Measurement sequencer and Avalon-MM register slave: arms the meter,
// averages results, publishes N/M, raises irq and retunes the AD divider.
module freq_meas_ctrl
  import freq_meas_pkg::*;
#(
  parameter int N_W          = DEF_N_W,
  parameter int M_W          = DEF_M_W,
  parameter int TO_W         = DEF_TO_W,
  parameter int AVG_LOG2_MAX = DEF_AVG_LOG2_MAX
) (
  input  logic                    clk,
  input  logic                    rst_n,
  freq_meas_ctrl_if.slave         bus,
  output logic                    irq,
  output logic                    meas_start,
  input  logic                    meas_done,
  input  logic [N_W-1:0]          meas_n,
  input  logic [M_W-1:0]          meas_m,
  output logic [M_W-1:0]          adclk_div,
  output logic                    adclk_div_load
);

  state_e          r_state;
  logic            r_run;
  logic [1:0]      r_avg;
  logic            r_irq_en;
  logic            r_track;
  logic            r_valid;
  logic            r_timeout_f;
  logic            r_overrun;
  logic [TO_W-1:0] r_timeout;
  logic [TO_W-1:0] r_to_cnt;
  logic [N_W-1:0]  r_n_res;
  logic [M_W-1:0]  r_m_res;
  logic [15:0]     r_meas_cnt;
  logic [M_W-1:0]  r_adclk_div;
  logic            r_div_load;
  logic            r_meas_start;
  logic            r_irq;
  logic [N_W-1:0]  r_cap_n;
  logic [M_W-1:0]  r_cap_m;

  logic            w_wr_ctrl;
  logic            w_wr_stat;
  logic            w_wr_to;
  logic            w_wr_div;
  logic            w_busy;
  logic            w_abort;
  logic            w_start;
  logic            w_to_hit;
  logic            w_acc_clr;
  logic            w_acc_add;
  logic            w_acc_sample;
  logic            w_last;
  logic [N_W-1:0]  w_avg_n;
  logic [M_W-1:0]  w_avg_m;
  logic [31:0]     w_rdata;
  logic            w_unused;

  assign w_wr_ctrl = bus.write && (bus.address == ADDR_CTRL);
  assign w_wr_stat = bus.write && (bus.address == ADDR_STATUS);
  assign w_wr_to   = bus.write && (bus.address == ADDR_TIMEOUT);
  assign w_wr_div  = bus.write && (bus.address == ADDR_DIV);
  assign w_busy    = (r_state != S_IDLE);
  // Clearing run while a measurement is in flight drops it on the spot
  assign w_abort   = w_wr_ctrl && !bus.writedata[CTRL_RUN] && w_busy;
  // A CTRL write decides the start itself so a run=1 then run=0 pair cannot slip a start through
  assign w_start   = w_wr_ctrl ? (bus.writedata[CTRL_RUN] | bus.writedata[CTRL_ONESHOT]) : r_run;
  assign w_to_hit  = (r_state == S_WAIT) && !meas_done && (r_timeout != '0) &&
                     (r_to_cnt == r_timeout);

  assign w_acc_clr    = w_abort || (r_state == S_RPT) || w_to_hit;
  assign w_acc_add    = (r_state == S_ACC) && !w_abort;
  assign w_acc_sample = (r_state == S_ARM) && !w_abort;

  assign irq            = r_irq;
  assign meas_start     = r_meas_start;
  assign adclk_div      = r_adclk_div;
  assign adclk_div_load = r_div_load;
  assign w_unused       = ^bus.writedata;

  freq_meas_accum #(
    .N_W          (N_W),
    .M_W          (M_W),
    .AVG_LOG2_MAX (AVG_LOG2_MAX)
  ) u_accum (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_acc_clr),
    .i_add      (w_acc_add),
    .i_sample   (w_acc_sample),
    .i_avg_log2 (r_avg),
    .i_n        (r_cap_n),
    .i_m        (r_cap_m),
    .o_last     (w_last),
    .o_avg_n    (w_avg_n),
    .o_avg_m    (w_avg_m)
  );

  // Zero-wait-state register read mux
  always_comb begin
    w_rdata = '0;
    if (bus.read) begin
      case (bus.address)
        ADDR_CTRL: begin
          w_rdata[CTRL_RUN]           = r_run;
          w_rdata[CTRL_AVG_LO +: 2]   = r_avg;
          w_rdata[CTRL_IRQ_EN]        = r_irq_en;
          w_rdata[CTRL_TRACK]         = r_track;
        end
        ADDR_STATUS: begin
          w_rdata[STAT_BUSY]    = w_busy;
          w_rdata[STAT_VALID]   = r_valid;
          w_rdata[STAT_TIMEOUT] = r_timeout_f;
          w_rdata[STAT_OVERRUN] = r_overrun;
        end
        ADDR_N_RES:    w_rdata[N_W-1:0]  = r_n_res;
        ADDR_M_RES:    w_rdata[M_W-1:0]  = r_m_res;
        ADDR_TIMEOUT:  w_rdata[TO_W-1:0] = r_timeout;
        ADDR_MEAS_CNT: w_rdata[15:0]     = r_meas_cnt;
        ADDR_DIV:      w_rdata[M_W-1:0]  = r_adclk_div;
        default:       w_rdata           = '0;
      endcase
    end
  end

  assign bus.readdata = w_rdata;

  // Register file and measurement sequencer; hardware flag sets come last so they beat W1C
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_run        <= 1'b0;
      r_avg        <= '0;
      r_irq_en     <= 1'b0;
      r_track      <= 1'b0;
      r_valid      <= 1'b0;
      r_timeout_f  <= 1'b0;
      r_overrun    <= 1'b0;
      r_timeout    <= '0;
      r_to_cnt     <= '0;
      r_n_res      <= '0;
      r_m_res      <= '0;
      r_meas_cnt   <= '0;
      r_adclk_div  <= '0;
      r_div_load   <= 1'b0;
      r_meas_start <= 1'b0;
      r_irq        <= 1'b0;
      r_cap_n      <= '0;
      r_cap_m      <= '0;
    end else begin
      r_meas_start <= 1'b0;
      r_div_load   <= 1'b0;
      r_irq        <= r_irq_en && (r_valid || r_timeout_f);

      if (w_wr_ctrl) begin
        r_run    <= bus.writedata[CTRL_RUN];
        r_avg    <= bus.writedata[CTRL_AVG_LO +: 2];
        r_irq_en <= bus.writedata[CTRL_IRQ_EN];
        r_track  <= bus.writedata[CTRL_TRACK];
      end
      if (w_wr_to) begin
        r_timeout <= bus.writedata[TO_W-1:0];
      end
      if (w_wr_div) begin
        r_adclk_div <= bus.writedata[M_W-1:0];
        r_div_load  <= 1'b1;
      end
      if (w_wr_stat) begin
        if (bus.writedata[STAT_VALID])   r_valid     <= 1'b0;
        if (bus.writedata[STAT_TIMEOUT]) r_timeout_f <= 1'b0;
        if (bus.writedata[STAT_OVERRUN]) r_overrun   <= 1'b0;
      end

      if (w_abort) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_start) begin
              r_state      <= S_ARM;
              r_meas_start <= 1'b1;
            end
          end
          S_ARM: begin
            r_to_cnt <= '0;
            r_state  <= S_WAIT;
          end
          S_WAIT: begin
            if (meas_done) begin
              r_cap_n <= meas_n;
              r_cap_m <= meas_m;
              r_state <= S_ACC;
            end else if (w_to_hit) begin
              r_timeout_f <= 1'b1;
              r_run       <= 1'b0;
              r_state     <= S_IDLE;
            end else begin
              r_to_cnt <= r_to_cnt + 1'b1;
            end
          end
          S_ACC: begin
            if (w_last) begin
              r_state <= S_RPT;
            end else begin
              r_state      <= S_ARM;
              r_meas_start <= 1'b1;
            end
          end
          S_RPT: begin
            r_n_res    <= w_avg_n;
            r_m_res    <= w_avg_m;
            r_valid    <= 1'b1;
            if (r_valid) r_overrun <= 1'b1;
            r_meas_cnt <= r_meas_cnt + 1'b1;
            if (r_track) begin
              r_adclk_div <= w_avg_m;
              r_div_load  <= 1'b1;
            end
            if (r_run) begin
              r_state      <= S_ARM;
              r_meas_start <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Bench for freq_meas_ctrl: a meter model answers meas_start from value
// queues; expected results come from plain sums of the values supplied.
module tb_freq_meas_ctrl;

  localparam logic [2:0] A_CTRL = 3'd0, A_STAT = 3'd1, A_NRES = 3'd2, A_MRES = 3'd3;
  localparam logic [2:0] A_TO = 3'd4, A_CNT = 3'd5, A_DIV = 3'd6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        irq, meas_start, adclk_div_load;
  logic        meas_done;
  logic [21:0] meas_n;
  logic [12:0] meas_m;
  logic [12:0] adclk_div;

  int total = 0;
  int bad = 0;
  int n_starts = 0;
  int n_loads = 0;
  int cyc = 0;
  int exp_cnt = 0;

  logic [21:0] q_n[$];
  logic [12:0] q_m[$];
  logic [21:0] q_late[$];

  always #5 clk = ~clk;

  freq_meas_ctrl_if bus();

  freq_meas_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .irq            (irq),
    .meas_start     (meas_start),
    .meas_done      (meas_done),
    .meas_n         (meas_n),
    .meas_m         (meas_m),
    .adclk_div      (adclk_div),
    .adclk_div_load (adclk_div_load)
  );

  // Pulse counters
  initial forever begin
    @(posedge clk); #1;
    cyc++;
    if (meas_start === 1'b1) n_starts++;
    if (adclk_div_load === 1'b1) n_loads++;
  end

  // Meter model: answers each meas_start while it has queued values
  initial begin
    meas_done = 1'b0; meas_n = '0; meas_m = '0;
    forever begin
      @(posedge clk); #1;
      if (q_late.size() > 0) begin
        meas_n = q_late.pop_front(); meas_m = 13'd1; meas_done = 1'b1;
        @(posedge clk); #1; meas_done = 1'b0;
      end else if (meas_start === 1'b1 && q_n.size() > 0) begin
        repeat ($urandom_range(1, 6)) @(posedge clk);
        #1;
        meas_n = q_n.pop_front(); meas_m = q_m.pop_front(); meas_done = 1'b1;
        @(posedge clk); #1; meas_done = 1'b0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus.address = a; bus.writedata = d; bus.write = 1'b1;
    @(posedge clk); #1;
    bus.write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    bus.address = a; bus.read = 1'b1;
    #2;
    d = bus.readdata;
    bus.read = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    logic [31:0] s;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      rd(A_STAT, s);
      if (s[0] == 1'b0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_starts(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (n_starts >= target) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #2;
      if (meas_done === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    logic [31:0] d;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%0d want=0", irq); end
    total++; if (meas_start !== 1'b0) begin bad++; $display("FAIL reset_start got=%0d want=0", meas_start); end
    total++; if (adclk_div !== 13'd0) begin bad++; $display("FAIL reset_div got=%0d want=0", adclk_div); end
    total++; if (adclk_div_load !== 1'b0) begin bad++; $display("FAIL reset_load got=%0d want=0", adclk_div_load); end
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), d);
      total++; if (d !== 32'd0) begin bad++; $display("FAIL reset_reg%0d got=%h want=0", a, d); end
    end
  endtask

  task automatic test_average;
    logic [31:0] d;
    bit ok;
    int a, s0;
    longint sn, sm;
    logic [21:0] vn;
    logic [12:0] vm;
    for (int t = 0; t < 6; t++) begin
      a = (t == 0) ? 2 : int'($urandom_range(0, 3));
      sn = 0; sm = 0;
      for (int i = 0; i < (1 << a); i++) begin
        vn = (t == 0) ? 22'(100 + i + ((i == 3) ? 1 : 0)) : 22'($urandom_range(0, 32'h3FFFFF));
        vm = 13'($urandom_range(0, 8191));
        q_n.push_back(vn); q_m.push_back(vm);
        sn += longint'(vn); sm += longint'(vm);
      end
      s0 = n_starts;
      wr(A_CTRL, (32'(a) << 4) | 32'h2);
      wait_idle(ok);
      total++; if (!ok) begin bad++; $display("FAIL avg_idle t=%0d got=busy want=idle", t); end
      exp_cnt++;
      total++; if (n_starts - s0 != (1 << a)) begin bad++; $display("FAIL avg_starts got=%0d want=%0d", n_starts - s0, 1 << a); end
      rd(A_NRES, d);
      total++; if (d !== 32'(sn >> a)) begin bad++; $display("FAIL avg_nres got=%0d want=%0d", d, sn >> a); end
      rd(A_MRES, d);
      total++; if (d !== 32'(sm >> a)) begin bad++; $display("FAIL avg_mres got=%0d want=%0d", d, sm >> a); end
      rd(A_STAT, d);
      total++; if (d !== 32'h2) begin bad++; $display("FAIL avg_status got=%h want=2", d); end
      rd(A_CNT, d);
      total++; if (d !== 32'(exp_cnt)) begin bad++; $display("FAIL avg_cnt got=%0d want=%0d", d, exp_cnt); end
      wr(A_STAT, 32'hE);
    end
  endtask

  task automatic test_continuous;
    logic [31:0] d;
    bit ok;
    int s0;
    s0 = n_starts;
    for (int i = 0; i < 3; i++) begin q_n.push_back(22'd1000); q_m.push_back(13'd50); end
    wr(A_CTRL, 32'h1);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      rd(A_CNT, d);
      if (d == 32'(exp_cnt + 3)) begin ok = 1'b1; break; end
    end
    exp_cnt += 3;
    total++; if (!ok) begin bad++; $display("FAIL cont_cnt got=%0d want=%0d", d, exp_cnt); end
    wr(A_CTRL, 32'h0);
    repeat (3) @(posedge clk);
    total++; if (n_starts - s0 != 4) begin bad++; $display("FAIL cont_starts got=%0d want=4", n_starts - s0); end
    rd(A_NRES, d);
    total++; if (d !== 32'd1000) begin bad++; $display("FAIL cont_nres got=%0d want=1000", d); end
    rd(A_MRES, d);
    total++; if (d !== 32'd50) begin bad++; $display("FAIL cont_mres got=%0d want=50", d); end
    rd(A_STAT, d);
    total++; if (d !== 32'hA) begin bad++; $display("FAIL cont_overrun got=%h want=a", d); end
    wr(A_STAT, 32'hE);
    rd(A_STAT, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL cont_w1c got=%h want=0", d); end
  endtask

  task automatic test_timeout;
    logic [31:0] d;
    bit ok;
    int s0, t0;
    wr(A_TO, 32'd20);
    s0 = n_starts;
    wr(A_CTRL, 32'h101);
    wait_starts(s0 + 1, ok);
    t0 = cyc;
    total++; if (!ok) begin bad++; $display("FAIL to_start got=%0d want=%0d", n_starts, s0 + 1); end
    repeat (12) @(posedge clk);
    rd(A_STAT, d);
    total++; if (d[2:0] !== 3'b001) begin bad++; $display("FAIL to_early got=%b want=001", d[2:0]); end
    wait_idle(ok);
    total++; if (!ok || (cyc - t0) < 20 || (cyc - t0) > 28) begin
      bad++; $display("FAIL to_elapsed got=%0d want=20..28", cyc - t0);
    end
    rd(A_STAT, d);
    total++; if (d !== 32'h4) begin bad++; $display("FAIL to_status got=%h want=4", d); end
    rd(A_CTRL, d);
    total++; if (d[0] !== 1'b0) begin bad++; $display("FAIL to_run got=%0d want=0", d[0]); end
    total++; if (n_starts - s0 != 1) begin bad++; $display("FAIL to_starts got=%0d want=1", n_starts - s0); end
    repeat (2) @(posedge clk);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL to_irq got=%0d want=1", irq); end
    wr(A_TO, 32'd0);
    wr(A_STAT, 32'hE);
    repeat (2) @(posedge clk);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL to_irq_clr got=%0d want=0", irq); end
    wr(A_CTRL, 32'h0);
  endtask

  task automatic test_w1c_race;
    logic [31:0] d;
    bit ok;
    logic [21:0] v;
    q_n.push_back(22'd7); q_m.push_back(13'd3);
    wr(A_CTRL, 32'h2);
    wait_idle(ok);
    exp_cnt++;
    v = 22'($urandom_range(0, 32'h3FFFFF));
    q_n.push_back(v); q_m.push_back(13'd9);
    wr(A_CTRL, 32'h2);
    wait_done(ok);
    total++; if (!ok) begin bad++; $display("FAIL race_done got=0 want=1"); end
    @(posedge clk);
    wr(A_STAT, 32'hE);
    wait_idle(ok);
    exp_cnt++;
    rd(A_STAT, d);
    total++; if (d !== 32'hA) begin bad++; $display("FAIL race_status got=%h want=a", d); end
    rd(A_NRES, d);
    total++; if (d !== 32'(v)) begin bad++; $display("FAIL race_nres got=%0d want=%0d", d, v); end
    wr(A_STAT, 32'hE);
  endtask

  task automatic test_track_div;
    logic [31:0] d;
    bit ok;
    int l0;
    logic [12:0] m2;
    l0 = n_loads;
    q_n.push_back(22'($urandom_range(0, 32'h3FFFFF))); q_m.push_back(13'd37);
    wr(A_CTRL, 32'h202);
    wait_idle(ok);
    exp_cnt++;
    total++; if (adclk_div !== 13'd37) begin bad++; $display("FAIL track_div got=%0d want=37", adclk_div); end
    total++; if (n_loads - l0 != 1) begin bad++; $display("FAIL track_loads got=%0d want=1", n_loads - l0); end
    rd(A_DIV, d);
    total++; if (d !== 32'd37) begin bad++; $display("FAIL track_rd got=%0d want=37", d); end
    wr(A_DIV, 32'd12);
    total++; if (adclk_div !== 13'd12 || adclk_div_load !== 1'b1) begin
      bad++; $display("FAIL divwr got=%0d/%0d want=12/1", adclk_div, adclk_div_load);
    end
    repeat (2) @(posedge clk);
    total++; if (n_loads - l0 != 2) begin bad++; $display("FAIL divwr_loads got=%0d want=2", n_loads - l0); end
    m2 = 13'($urandom_range(100, 8000));
    q_n.push_back(22'd1); q_m.push_back(m2);
    wr(A_CTRL, 32'h202);
    wait_done(ok);
    @(posedge clk);
    wr(A_DIV, 32'd5);
    wait_idle(ok);
    exp_cnt++;
    total++; if (adclk_div !== m2) begin bad++; $display("FAIL div_prio got=%0d want=%0d", adclk_div, m2); end
    wr(A_CTRL, 32'h0);
    wr(A_STAT, 32'hE);
  endtask

  task automatic test_abort;
    logic [31:0] d;
    bit ok;
    int s0;
    logic [21:0] a, b;
    s0 = n_starts;
    q_n.push_back(22'd500); q_m.push_back(13'd5);
    wr(A_CTRL, 32'h11);
    wait_starts(s0 + 2, ok);
    total++; if (!ok) begin bad++; $display("FAIL abort_starts got=%0d want=%0d", n_starts - s0, 2); end
    repeat (3) @(posedge clk);
    wr(A_CTRL, 32'h10);
    q_late.push_back(22'd555);
    repeat (10) @(posedge clk);
    rd(A_STAT, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL abort_status got=%h want=0", d); end
    rd(A_CNT, d);
    total++; if (d !== 32'(exp_cnt)) begin bad++; $display("FAIL abort_cnt got=%0d want=%0d", d, exp_cnt); end
    total++; if (n_starts - s0 != 2) begin bad++; $display("FAIL abort_nostart got=%0d want=2", n_starts - s0); end
    a = 22'($urandom_range(0, 32'h3FFFFF)); b = 22'($urandom_range(0, 32'h3FFFFF));
    q_n.push_back(a); q_m.push_back(13'd2);
    q_n.push_back(b); q_m.push_back(13'd4);
    wr(A_CTRL, 32'h12);
    wait_idle(ok);
    exp_cnt++;
    rd(A_NRES, d);
    total++; if (d !== 32'((longint'(a) + longint'(b)) >> 1)) begin
      bad++; $display("FAIL abort_fresh got=%0d want=%0d", d, (longint'(a) + longint'(b)) >> 1);
    end
    wr(A_STAT, 32'hE);
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    bit ok;
    int s0;
    wr(A_DIV, 32'd99);
    for (int i = 0; i < 8; i++) begin q_n.push_back(22'(i + 1)); q_m.push_back(13'(i)); end
    s0 = n_starts;
    wr(A_CTRL, 32'h131);
    wait_starts(s0 + 2, ok);
    #3 rst_n = 1'b0;
    #1;
    total++; if ({irq, meas_start, adclk_div_load} !== 3'b000 || adclk_div !== 13'd0) begin
      bad++; $display("FAIL rstmid_out got=%b/%0d want=000/0", {irq, meas_start, adclk_div_load}, adclk_div);
    end
    rd(A_STAT, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rstmid_status got=%h want=0", d); end
    rd(A_CNT, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rstmid_cnt got=%0d want=0", d); end
    q_n.delete(); q_m.delete();
    exp_cnt = 0;
    @(negedge clk); rst_n = 1'b1;
    s0 = n_starts;
    repeat (15) @(posedge clk);
    rd(A_STAT, d);
    total++; if (d !== 32'h0 || n_starts != s0) begin
      bad++; $display("FAIL rstmid_after got=%h/%0d want=0/0", d, n_starts - s0);
    end
  endtask

  initial begin
    bus.address = '0; bus.write = 1'b0; bus.writedata = '0; bus.read = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    test_reset;
    test_average;
    test_continuous;
    test_timeout;
    test_w1c_race;
    test_track_div;
    test_abort;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/freq_meas_ctrl.md
Name: freq_meas_ctrl

Overview:
Measurement sequencer and Avalon-MM control slave for the frequency-meter datapath (gate counter producing N/M) and the AD sample-clock divider.
- Arms the meter, waits for completion with a timeout, and averages 1/2/4/8 results.
- Publishes averaged N/M, raises an interrupt, and can retune the AD clock divider from the measured M.
- Sits between the Nios/Avalon fabric and the meter/divider pair, replacing direct software polling.

Parameters:
N_W, 22, width of meter N count
M_W, 13, width of meter M count and divider value
TO_W, 24, width of timeout counter
AVG_LOG2_MAX, 3, maximum log2 of the averaging depth

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
address  in  3  Avalon word address
write  in  1  Avalon write strobe
writedata  in  32  Avalon write data
read  in  1  Avalon read strobe
readdata  out  32  Avalon read data, zero wait state
irq  out  1  level interrupt
meas_start  out  1  one-cycle pulse that arms the meter
meas_done  in  1  one-cycle pulse; meas_n and meas_m are valid in that cycle
meas_n  in  N_W  meter N result
meas_m  in  M_W  meter M result
adclk_div  out  M_W  divider value to the AD clock generator
adclk_div_load  out  1  one-cycle pulse; divider takes adclk_div

Behaviour:
- Register map:
  - 0 CTRL (RW): bit0 run (continuous), bit1 oneshot (self-clearing), bits[5:4] avg_log2, bit8 irq_en, bit9 track_div.
  - 1 STATUS: bit0 busy (RO); bits 1 valid, 2 timeout, 3 overrun are W1C.
  - 2 N_RES (RO), zero-extended.
  - 3 M_RES (RO), zero-extended.
  - 4 TIMEOUT (RW, TO_W bits; 0 disables timeout).
  - 5 MEAS_CNT (RO, 16-bit, wraps 0xFFFF->0).
  - 6 DIV (RW, M_W bits).
  - 7 reads 0; writes to it are ignored.
- readdata is combinational from address when read=1, else 0.
- Reset values: all registers 0, state IDLE, irq=0, meas_start=0, adclk_div=0, adclk_div_load=0.
- FSM transitions:
  - IDLE -> ARM when run=1 or oneshot is written 1.
  - ARM: meas_start=1 for exactly one cycle; clears the timeout counter; -> WAIT.
  - WAIT: timeout counter increments each cycle.
    - meas_done -> ACC.
    - counter == TIMEOUT (nonzero) -> set timeout, clear run, clear accumulators -> IDLE.
  - ACC (1 cycle):
    - acc_n += meas_n; acc_m += meas_m; k += 1.
    - If k reaches 2^avg_log2 -> RPT, else -> ARM.
  - RPT (1 cycle):
    - N_RES = acc_n >> avg_log2 (truncating); M_RES = acc_m >> avg_log2.
    - Set valid; if valid was already 1, also set overrun.
    - MEAS_CNT += 1; clear accumulators and k.
    - If track_div=1: adclk_div <= M_RES value and adclk_div_load pulses in the next cycle.
    - -> ARM if run=1, else IDLE.
- Accumulator widths: N_W+AVG_LOG2_MAX and M_W+AVG_LOG2_MAX bits; no overflow is possible.
- avg_log2 is sampled in ARM when k=0; changes mid-average take effect on the next average.
- A write to DIV updates adclk_div and pulses adclk_div_load the next cycle. An RPT load in the same cycle takes priority over the DIV write.
- Writing run=0 while busy aborts at the next clock edge: -> IDLE, accumulators cleared, no status change. A meas_done arriving after the abort is ignored.
- A meas_done outside WAIT is ignored.
- W1C and a hardware set on the same cycle: the set wins.
- busy = (state != IDLE).
- irq = irq_en & (valid | timeout), registered (one cycle after the flag).
- Reset asserted mid-operation returns everything to reset values immediately.

Decomposition:
- Package freq_meas_pkg holds:
  - state encoding (IDLE, ARM, WAIT, ACC, RPT);
  - register address constants;
  - CTRL/STATUS bit positions;
  - default widths.
- Sub-module freq_meas_accum: accumulators, sample counter k, and the shift-average output, with clear/add/done handshake.

Test Plan:
- run=1, avg_log2=0, meter returns N=1000, M=50 -> one meas_start per measurement; N_RES=1000, M_RES=50; valid=1, MEAS_CNT=1.
- avg_log2=2, meter returns N=100,101,102,104 -> exactly 4 meas_start pulses, then N_RES=101 (407>>2).
- TIMEOUT=20, meas_done never asserted -> timeout=1 after 20 WAIT cycles, run=0, busy=0, irq=1 when irq_en=1.
- Continuous run with valid never cleared -> second report sets overrun=1. W1C 0x0E to STATUS -> flags clear. W1C in the same cycle as RPT -> valid remains 1.
- track_div=1, M=37 -> adclk_div=37 and one adclk_div_load pulse. DIV write of 12 -> adclk_div=12 on the next cycle.
- run cleared in WAIT, then a late meas_done -> state IDLE, MEAS_CNT unchanged. rst_n pulsed mid-average -> all outputs 0.
